// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, drives the ROM address and buffers fetched
// {pc, instr} pairs in a 2-entry queue presented to decode over valid/ready.
module instruction_fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] Address_o,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Redirect_Target_i,
    input  logic                  Halt_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [DATA_WIDTH-1:0] Instruction_o,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic                  Misaligned_o,
    output logic [31:0]           Fetch_Count_o
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] buf_pc_q    [2];
    logic [DATA_WIDTH-1:0] buf_instr_q [2];
    logic                  rd_ptr_q;
    logic                  rd_ptr_d;
    logic                  wr_ptr_q;
    logic                  wr_ptr_d;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic [31:0]           fetch_count_q;
    logic                  misaligned_q;
    logic                  misaligned_d;

    logic valid;
    logic pop;
    logic push;

    assign valid = (count_q != 2'd0);
    assign pop   = valid & Ready_i;
    // A full buffer can still accept a fetch in the cycle it hands one to decode.
    assign push  = ~Halt_i & ~Redirect_i & ((count_q < 2'd2) | pop);

    assign misaligned_d = Redirect_i & (Redirect_Target_i[1:0] != 2'b00);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Redirect_i) begin
            // Flush everything; a same-cycle pop is still counted as delivered.
            pc_d     = {Redirect_Target_i[DATA_WIDTH-1:2], 2'b00};
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                pc_d     = pc_q + DATA_WIDTH'(4);
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            fetch_count_q <= 32'd0;
            misaligned_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_count_q <= fetch_count_q + {31'd0, pop};
            misaligned_q  <= misaligned_d;
        end
    end

    // Entry storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_pc_q[wr_ptr_q]    <= pc_q;
            buf_instr_q[wr_ptr_q] <= Instruction_i;
        end
    end

    assign Address_o     = pc_q;
    assign Valid_o       = valid;
    assign Instruction_o = valid ? buf_instr_q[rd_ptr_q] : NOP_INSTR;
    assign PC_o          = valid ? buf_pc_q[rd_ptr_q] : '0;
    assign Misaligned_o  = misaligned_q;
    assign Fetch_Count_o = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address_o;
    logic [31:0] Instruction_i;
    logic        Redirect_i;
    logic [31:0] Redirect_Target_i;
    logic        Halt_i;
    logic        Valid_o;
    logic        Ready_i;
    logic [31:0] Instruction_o;
    logic [31:0] PC_o;
    logic        Misaligned_o;
    logic [31:0] Fetch_Count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // ROM: word[i] = 0x100 + i, with index 0 at the text-segment base.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h100 + ((a - RESET_PC) >> 2);
    endfunction

    assign Instruction_i = rom(Address_o);

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .Address_o        (Address_o),
        .Instruction_i    (Instruction_i),
        .Redirect_i       (Redirect_i),
        .Redirect_Target_i(Redirect_Target_i),
        .Halt_i           (Halt_i),
        .Valid_o          (Valid_o),
        .Ready_i          (Ready_i),
        .Instruction_o    (Instruction_o),
        .PC_o             (PC_o),
        .Misaligned_o     (Misaligned_o),
        .Fetch_Count_o    (Fetch_Count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of fetched {pc, instr} pairs.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fc;
    logic        m_mis;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (reset) begin
            q.delete();
            m_pc   = RESET_PC;
            m_fc   = 32'd0;
            m_mis  = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            do_pop  = (q.size() > 0) && Ready_i;
            do_push = !Halt_i && !Redirect_i && ((q.size() < 2) || do_pop);
            if (do_pop) begin
                void'(q.pop_front());
                m_fc = m_fc + 32'd1;
            end
            m_mis = Redirect_i && (Redirect_Target_i[1:0] != 2'b00);
            if (Redirect_i) begin
                q.delete();
                m_pc = Redirect_Target_i & 32'hFFFF_FFFC;
            end else if (do_push) begin
                q.push_back('{pc: m_pc, instr: rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_addr", Address_o, m_pc);
            chk("m_valid", {31'd0, Valid_o}, {31'd0, q.size() != 0});
            chk("m_instr", Instruction_o, (q.size() != 0) ? q[0].instr : NOP_INSTR);
            chk("m_pc", PC_o, (q.size() != 0) ? q[0].pc : 32'd0);
            chk("m_mis", {31'd0, Misaligned_o}, {31'd0, m_mis});
            chk("m_fcount", Fetch_Count_o, m_fc);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] fc_snap;

    initial begin
        reset = 1'b1; Ready_i = 1'b0; Halt_i = 1'b0;
        Redirect_i = 1'b0; Redirect_Target_i = 32'd0;
        cyc(2);
        chk("rst_valid", {31'd0, Valid_o}, 32'd0);
        chk("rst_instr", Instruction_o, 32'h13);
        chk("rst_pc", PC_o, 32'd0);
        chk("rst_addr", Address_o, 32'h0040_0000);
        chk("rst_fcount", Fetch_Count_o, 32'd0);

        // Streaming from reset release.
        reset = 1'b0; Ready_i = 1'b1;
        cyc(1);
        chk("s_instr0", Instruction_o, 32'h100);
        chk("s_pc0", PC_o, 32'h0040_0000);
        chk("s_addr1", Address_o, 32'h0040_0004);
        cyc(1);
        chk("s_instr1", Instruction_o, 32'h101);
        cyc(1);
        chk("s_instr2", Instruction_o, 32'h102);
        chk("s_pc2", PC_o, 32'h0040_0008);
        cyc(1);
        chk("s_fcount3", Fetch_Count_o, 32'd3);

        // Backpressure from reset.
        reset = 1'b1; Ready_i = 1'b0;
        cyc(1);
        reset = 1'b0;
        cyc(5);
        chk("bp_valid", {31'd0, Valid_o}, 32'd1);
        chk("bp_addr", Address_o, 32'h0040_0008);
        chk("bp_head", Instruction_o, 32'h100);
        Ready_i = 1'b1;
        cyc(1);
        chk("bp_i1", Instruction_o, 32'h101);
        cyc(1);
        chk("bp_i2", Instruction_o, 32'h102);
        cyc(1);
        chk("bp_i3", Instruction_o, 32'h103);

        // Redirect with a full buffer to a misaligned target.
        Ready_i = 1'b0;
        cyc(2);
        Redirect_i = 1'b1; Redirect_Target_i = 32'h0040_0022;
        cyc(1);
        chk("rd_valid", {31'd0, Valid_o}, 32'd0);
        chk("rd_addr", Address_o, 32'h0040_0020);
        chk("rd_mis", {31'd0, Misaligned_o}, 32'd1);
        Redirect_i = 1'b0; Ready_i = 1'b1;
        cyc(1);
        chk("rd_instr", Instruction_o, 32'h108);
        chk("rd_pc", PC_o, 32'h0040_0020);
        chk("rd_mis_off", {31'd0, Misaligned_o}, 32'd0);

        // Redirect and pop together: popped head counts, second entry dropped.
        Ready_i = 1'b0;
        cyc(1);
        fc_snap = Fetch_Count_o;
        Ready_i = 1'b1; Redirect_i = 1'b1; Redirect_Target_i = 32'h0040_0040;
        cyc(1);
        chk("rp_fcount", Fetch_Count_o, fc_snap + 32'd1);
        chk("rp_valid", {31'd0, Valid_o}, 32'd0);
        Redirect_i = 1'b0;
        cyc(1);
        chk("rp_instr", Instruction_o, 32'h110);

        // Halt drains the buffer and holds the PC.
        Halt_i = 1'b1;
        cyc(4);
        chk("h_valid", {31'd0, Valid_o}, 32'd0);
        chk("h_addr", Address_o, 32'h0040_0044);
        Halt_i = 1'b0;
        cyc(1);
        chk("h_instr", Instruction_o, 32'h111);
        chk("h_pc", PC_o, 32'h0040_0044);
        cyc(1);
        chk("h_instr2", Instruction_o, 32'h112);

        // PC wrap, then reset with a full buffer and a pending redirect.
        Ready_i = 1'b0; Redirect_i = 1'b1; Redirect_Target_i = 32'hFFFF_FFFC;
        cyc(1);
        chk("w_addr", Address_o, 32'hFFFF_FFFC);
        Redirect_i = 1'b0;
        cyc(1);
        chk("w_wrap", Address_o, 32'h0000_0000);
        cyc(1);
        chk("w_full_addr", Address_o, 32'h0000_0004);
        reset = 1'b1; Redirect_i = 1'b1; Redirect_Target_i = 32'h0040_0101;
        cyc(1);
        chk("wr_valid", {31'd0, Valid_o}, 32'd0);
        chk("wr_addr", Address_o, 32'h0040_0000);
        chk("wr_fcount", Fetch_Count_o, 32'd0);
        chk("wr_mis", {31'd0, Misaligned_o}, 32'd0);
        reset = 1'b0; Redirect_i = 1'b0; Ready_i = 1'b1;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch front end that sits directly upstream of the combinational program-memory ROM.
- Owns the program counter and drives the ROM address every cycle.
- Captures the returned instruction word, together with its PC, into a 2-entry fetch buffer.
- Presents buffered instructions to the decode stage over a valid/ready handshake, with redirect (branch/jump) flush, halt and a delivered-instruction counter.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0040_0000, PC loaded on reset (text-segment base; ROM index 0).
- NOP_INSTR, 32'h0000_0013, value driven on Instruction_o when the buffer is empty.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Address_o  output  DATA_WIDTH  fetch address to program memory; equals pc_q.
- Instruction_i  input  DATA_WIDTH  ROM data for Address_o, valid combinationally in the same cycle.
- Redirect_i  input  1  taken branch/jump; flush and reload PC.
- Redirect_Target_i  input  DATA_WIDTH  new fetch address.
- Halt_i  input  1  suppress new fetches; buffer continues to drain.
- Valid_o  output  1  buffer head holds a valid instruction.
- Ready_i  input  1  decode accepts head this cycle.
- Instruction_o  output  DATA_WIDTH  head instruction, or NOP_INSTR when empty.
- PC_o  output  DATA_WIDTH  PC of head instruction, or 0 when empty.
- Misaligned_o  output  1  one-cycle pulse: the accepted redirect target had bits [1:0] != 0.
- Fetch_Count_o  output  32  number of instructions handed to decode since reset.

Behaviour:
- State: pc_q; 2-entry circular buffer of {pc, instr} with 1-bit rd/wr pointers and a 2-bit count (0..2); Fetch_Count register; Misaligned register.
- Reset (synchronous, active-high):
  - pc_q=RESET_PC, count=0, pointers=0, Fetch_Count_o=0, Misaligned_o=0.
  - Therefore Valid_o=0, Instruction_o=NOP_INSTR, PC_o=0, Address_o=RESET_PC.
  - Reset wins over every other input, including mid-redirect and with a full buffer.
- pop = Valid_o & Ready_i. Valid_o = (count != 0).
- push = !Halt_i & !Redirect_i & (count < 2 | pop). A full buffer accepts a push in the same cycle it pops.
- On push:
  - Write {pc_q, Instruction_i} at wr_ptr.
  - pc_q <= pc_q + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- count next = count + push - pop. Simultaneous push and pop at count 1 or 2 leaves count unchanged.
- Latency:
  - An instruction fetched in cycle N appears on Valid_o/Instruction_o in cycle N+1.
  - Sustained throughput is 1 instruction per cycle while Ready_i=1 and Halt_i=0.
- Redirect_i=1 (priority over push, pop-related buffer state and Halt_i):
  - count<=0 and pointers<=0; all buffered entries are discarded.
  - pc_q <= {Redirect_Target_i[31:2], 2'b00}.
  - No push occurs in the redirect cycle.
  - If a pop occurs in the same cycle (Valid_o & Ready_i), that head instruction counts as delivered: Fetch_Count increments. Decode owns squashing it.
  - First post-redirect instruction reaches Valid_o two cycles after the redirect cycle: fetch in the cycle after the redirect, appear in the cycle after that.
- Misaligned_o <= Redirect_i & (Redirect_Target_i[1:0] != 0). Low for one cycle otherwise; not sticky.
- Halt_i=1: pc_q holds and nothing is pushed. Pops continue. Deasserting Halt_i resumes fetching from the held pc_q.
- Fetch_Count_o increments by 1 on every pop and wraps at 2^32.
- Empty buffer with Ready_i=1: no pop, no counter change.
- Full buffer with Ready_i=0: no push, pc_q holds, Address_o stable.
- Instruction_o/PC_o are read combinationally from the rd_ptr entry, muxed to NOP_INSTR/0 when count=0.

Test Plan:
- Reset release, ROM word[i]=0x100+i, Ready_i=1: Address_o sequence 0x00400000, 0x00400004, ...; Valid_o rises one cycle after reset release; Instruction_o 0x100, 0x101, 0x102 on consecutive cycles with PC_o matching; Fetch_Count_o=3 after three cycles.
- Backpressure: Ready_i=0 for 5 cycles from reset: count saturates at 2, Address_o frozen at 0x00400008; Ready_i=1 then delivers 0x100, 0x101, 0x102 with no gap or duplicate.
- Redirect with full buffer, Redirect_Target_i=0x00400022: next cycle Valid_o=0, Address_o=0x00400020, Misaligned_o=1 for exactly one cycle; following cycle Instruction_o=word[8], PC_o=0x00400020.
- Redirect and pop in the same cycle: Fetch_Count_o increments by 1; the discarded second entry never appears.
- Halt_i=1 for 4 cycles with Ready_i=1: buffer drains to Valid_o=0, Address_o held; Halt_i=0 resumes at the held PC in order.
- Wrap and reset mid-run: redirect to 0xFFFFFFFC, one push -> Address_o=0x00000000; assert reset while count=2 -> next cycle Valid_o=0, Address_o=0x00400000, Fetch_Count_o=0.
